// File: rtl/dual_port_memory.sv
// Dual-port (1W/1R) memory with power-up clear sweep and write-first read.
// Ports: Clock, Reset, Ready, WrEn/WrAddr/WrData/WrMask, RdEn/RdAddr, RdData/RdValid.
module dual_port_memory #(
  parameter int          N        = 8,
  parameter int          M        = 2,
  parameter logic [N-1:0] INIT_VAL = '0
) (
  input  logic         Clock,
  input  logic         Reset,
  output logic         Ready,
  input  logic         WrEn,
  input  logic [M-1:0] WrAddr,
  input  logic [N-1:0] WrData,
  input  logic [N-1:0] WrMask,
  input  logic         RdEn,
  input  logic [M-1:0] RdAddr,
  output logic [N-1:0] RdData,
  output logic         RdValid
);

  localparam int DEPTH = 1 << M;
  localparam logic [M:0] LAST = {1'b0, {M{1'b1}}};

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [M:0]     cnt_q, cnt_d;
  logic           sweep_we;
  logic           run;

  logic [N-1:0]   mem_q [DEPTH];
  logic [N-1:0]   wr_old;
  logic [N-1:0]   wr_merged;
  logic           wr_fire;
  logic           rd_fire;
  logic           rd_fwd;
  logic [N-1:0]   rd_next;

  logic [N-1:0]   rd_data_q;
  logic           rd_valid_q;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter parks at DEPTH once the sweep is done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    sweep_we = 1'b0;
    run      = 1'b0;
    unique case (state_q)
      S_CLEAR: sweep_we = 1'b1;
      S_RUN:   run      = 1'b1;
      default: run      = 1'b0;
    endcase
  end

  assign Ready = run;

  assign wr_fire   = run & WrEn;
  assign rd_fire   = run & RdEn;
  assign wr_old    = mem_q[WrAddr];
  assign wr_merged = (wr_old & ~WrMask) | (WrData & WrMask);

  // Same-address read sees the merged write value
  assign rd_fwd  = wr_fire && (WrAddr == RdAddr);
  assign rd_next = rd_fwd ? wr_merged : mem_q[RdAddr];

  // Storage array: no reset, contents defined by the sweep
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (sweep_we) begin
        mem_q[cnt_q[M-1:0]] <= INIT_VAL;
      end else if (wr_fire) begin
        mem_q[WrAddr] <= wr_merged;
      end
    end
  end

  // Registered read port
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= rd_next;
    end
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;

endmodule

// File: tb/tb_dual_port_memory.sv
// Directed testbench for dual_port_memory (M=2 default and M=3/INIT=FF).
// Immediate assertions at each check, summary line at the end.
module tb_dual_port_memory;

  logic       Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset, Ready, WrEn, RdEn, RdValid;
  logic [1:0] WrAddr, RdAddr;
  logic [7:0] WrData, WrMask, RdData;

  logic       Reset2, Ready2, WrEn2, RdEn2, RdValid2;
  logic [2:0] WrAddr2, RdAddr2;
  logic [7:0] WrData2, WrMask2, RdData2;

  int errors = 0;
  int checks = 0;

  dual_port_memory #(.N(8), .M(2), .INIT_VAL(8'h00)) dut (
    .Clock(Clock), .Reset(Reset), .Ready(Ready),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrMask(WrMask),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData), .RdValid(RdValid)
  );

  dual_port_memory #(.N(8), .M(3), .INIT_VAL(8'hFF)) dut3 (
    .Clock(Clock), .Reset(Reset2), .Ready(Ready2),
    .WrEn(WrEn2), .WrAddr(WrAddr2), .WrData(WrData2), .WrMask(WrMask2),
    .RdEn(RdEn2), .RdAddr(RdAddr2), .RdData(RdData2), .RdValid(RdValid2)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d,
                    input logic [7:0] m);
    WrEn = 1; WrAddr = a; WrData = d; WrMask = m;
    step();
    WrEn = 0;
  endtask

  initial begin
    Reset = 1; WrEn = 0; RdEn = 0; WrAddr = 0; RdAddr = 0;
    WrData = 0; WrMask = 0;
    Reset2 = 1; WrEn2 = 0; RdEn2 = 0; WrAddr2 = 0; RdAddr2 = 0;
    WrData2 = 0; WrMask2 = 0;

    step(); step();
    chk("rst_ready", Ready, 0);
    chk("rst_valid", RdValid, 0);
    chk("rst_data", RdData, 0);

    // Sweep: Ready rises after the 4th edge
    Reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("sweep_ready%0d", i), Ready, (i == 3));
      chk($sformatf("sweep_valid%0d", i), RdValid, 0);
    end

    // Read all cells after clear
    for (int i = 0; i < 4; i++) begin
      RdEn = 1; RdAddr = i[1:0];
      step();
      chk($sformatf("clr_valid%0d", i), RdValid, 1);
      chk($sformatf("clr_data%0d", i), RdData, 8'h00);
    end
    RdEn = 0;
    step();
    chk("idle_valid", RdValid, 0);

    // Masked writes: A5 then 0F/0F -> AF
    wr(2'd2, 8'hA5, 8'hFF);
    wr(2'd2, 8'h0F, 8'h0F);
    RdEn = 1; RdAddr = 2;
    step();
    RdEn = 0;
    chk("mask_valid", RdValid, 1);
    chk("mask_data", RdData, 8'hAF);

    // Same-address write + read: write-first
    WrEn = 1; WrAddr = 1; WrData = 8'h3C; WrMask = 8'hFF;
    RdEn = 1; RdAddr = 1;
    step();
    WrEn = 0; RdEn = 0;
    chk("fwd_valid", RdValid, 1);
    chk("fwd_data", RdData, 8'h3C);

    wr(2'd0, 8'h11, 8'hFF);
    wr(2'd3, 8'h77, 8'hFF);

    // Back-to-back reads 0..3
    begin
      logic [7:0] exp_b2b [4];
      exp_b2b[0] = 8'h11; exp_b2b[1] = 8'h3C;
      exp_b2b[2] = 8'hAF; exp_b2b[3] = 8'h77;
      for (int i = 0; i < 4; i++) begin
        RdEn = 1; RdAddr = i[1:0];
        step();
        chk($sformatf("b2b_valid%0d", i), RdValid, 1);
        chk($sformatf("b2b_data%0d", i), RdData, exp_b2b[i]);
      end
    end
    RdEn = 0;
    step();
    chk("hold_valid", RdValid, 0);
    chk("hold_data", RdData, 8'h77);

    // Different-address write + read in one cycle
    WrEn = 1; WrAddr = 0; WrData = 8'h55; WrMask = 8'hFF;
    RdEn = 1; RdAddr = 3;
    step();
    WrEn = 0;
    chk("diff_rd", RdData, 8'h77);
    RdAddr = 0;
    step();
    RdEn = 0;
    chk("diff_wr", RdData, 8'h55);

    // Zero mask leaves the cell unchanged
    wr(2'd0, 8'hFF, 8'h00);
    RdEn = 1; RdAddr = 0;
    step();
    RdEn = 0;
    chk("mask0", RdData, 8'h55);

    // Read issued as Reset asserts is discarded
    Reset = 1; RdEn = 1; RdAddr = 3;
    step();
    RdEn = 0;
    chk("rst_rd_valid", RdValid, 0);
    chk("rst_rd_data", RdData, 0);
    chk("rst_rd_ready", Ready, 0);

    // Reset at cycle 2 of a sweep, writes during sweep ignored
    Reset = 0;
    step(); step();
    Reset = 1;
    step();
    Reset = 0;
    WrEn = 1; WrAddr = 3; WrData = 8'hAA; WrMask = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("resweep_ready%0d", i), Ready, (i == 3));
    end
    WrEn = 0;
    for (int i = 0; i < 4; i++) begin
      RdEn = 1; RdAddr = i[1:0];
      step();
      chk($sformatf("resweep_data%0d", i), RdData, 8'h00);
    end
    RdEn = 0;

    // M=3, INIT_VAL=FF instance
    Reset2 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("m3_ready%0d", i), Ready2, (i == 7));
    end
    WrEn2 = 1; WrAddr2 = 7; WrData2 = 8'h12; WrMask2 = 8'hFF;
    RdEn2 = 1; RdAddr2 = 0;
    step();
    WrEn2 = 0;
    chk("m3_rd0_valid", RdValid2, 1);
    chk("m3_rd0_data", RdData2, 8'hFF);
    RdAddr2 = 7;
    step();
    RdEn2 = 0;
    chk("m3_rd7_data", RdData2, 8'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
